clint_mmio: RTL

// Multi-hart Core Local Interruptor with a memory-mapped register port. Owns the shared
// 64-bit mtime counter, with a prescaler and an inhibit input, and a per-hart msip and

---
 rtl/clint_mmio.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/clint_mmio.sv
// Core Local Interruptor: shared 64-bit mtime with prescaler/inhibit, per-hart msip and
// mtimecmp behind a single-outstanding MMIO request/response port, registered mip outputs.
module clint_mmio #(
    parameter int unsigned NUM_HARTS = 1,
    parameter int unsigned BUS_W     = 32,
    parameter int unsigned TICK_DIV  = 1,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [BUS_W-1:0]          req_wdata,
    input  logic [BUS_W/8-1:0]        req_wstrb,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [BUS_W-1:0]          resp_rdata,
    output logic                      resp_err,
    input  logic                      tm_inhibit,
    input  logic [NUM_HARTS-1:0]      stce,
    input  logic [64*NUM_HARTS-1:0]   stimecmp,
    output logic [63:0]               time_o,
    output logic [NUM_HARTS-1:0]      mip_msip,
    output logic [NUM_HARTS-1:0]      mip_mtip,
    output logic [NUM_HARTS-1:0]      mip_stip
);

    localparam int unsigned NB    = BUS_W / 8;
    localparam int unsigned LANES = BUS_W / 32;
    localparam int unsigned PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_MSIP = 2'd1;
    localparam logic [1:0] K_CMP  = 2'd2;
    localparam logic [1:0] K_TIME = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic        ok;
        logic [31:0] hart;
        logic        half;
    } dec_t;

    // Decodes one 32-bit word of the register window; a wide bus access touches LANES words.
    function automatic dec_t decode(input logic [31:0] a);
        dec_t        d;
        logic [31:0] off;
        d   = '0;
        off = a - 32'h0000_4000;
        if (a < 32'h0000_4000) begin
            d.kind = K_MSIP;
            d.hart = a >> 2;
            d.ok   = (d.hart < NUM_HARTS);
        end else if (a < 32'h0000_BFF8) begin
            d.kind = K_CMP;
            d.hart = off >> 3;
            d.half = off[2];
            d.ok   = (d.hart < NUM_HARTS);
        end else if (a[31:3] == 29'h0000_17FF) begin
            d.kind = K_TIME;
            d.half = a[2];
            d.ok   = 1'b1;
        end else begin
            d.kind = K_NONE;
            d.ok   = 1'b0;
        end
        return d;
    endfunction

    logic [0:0]           state_q, state_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [BUS_W-1:0]     rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [63:0]          mtime_q, mtime_d;
    logic [NUM_HARTS-1:0] msip_q, msip_d;
    logic [63:0]          mtimecmp_q [NUM_HARTS];
    logic [63:0]          mtimecmp_d [NUM_HARTS];
    logic [NUM_HARTS-1:0] mtip_q, mtip_d;
    logic [NUM_HARTS-1:0] stip_q, stip_d;
    logic [NUM_HARTS-1:0] msipo_q, msipo_d;

    logic [31:0]      base_addr;
    dec_t             dec [LANES];
    logic             misaligned;
    logic             acc_err;
    logic             accept;
    logic             wr_en;
    logic [BUS_W-1:0] rd_word;
    logic             mtime_wr;
    logic [63:0]      mtime_wval;
    logic             tick;

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign time_o     = mtime_q;
    assign mip_msip   = msipo_q;
    assign mip_mtip   = mtip_q;
    assign mip_stip   = stip_q;

    always_comb begin
        base_addr = 32'(req_addr);
        for (int unsigned l = 0; l < LANES; l++) begin
            dec[l] = decode(base_addr + 32'(4 * l));
        end
        misaligned = ((base_addr & 32'(NB - 1)) != 32'd0);
        acc_err    = misaligned || !dec[0].ok;
        accept     = req_valid && (state_q == ST_IDLE);
        wr_en      = accept && req_we && !acc_err;
    end

    always_comb begin
        rd_word = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (dec[l].ok) begin
                case (dec[l].kind)
                    K_MSIP: begin
                        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
                            if (dec[l].hart == 32'(h)) rd_word[32*l +: 32] = {31'd0, msip_q[h]};
                        end
                    end
                    K_CMP: begin
                        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
                            if (dec[l].hart == 32'(h)) begin
                                rd_word[32*l +: 32] = dec[l].half ? mtimecmp_q[h][63:32]
                                                                  : mtimecmp_q[h][31:0];
                            end
                        end
                    end
                    K_TIME:  rd_word[32*l +: 32] = dec[l].half ? mtime_q[63:32] : mtime_q[31:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_wr   = 1'b0;
        mtime_wval = mtime_q;
        if (wr_en) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                case (dec[l].kind)
                    K_MSIP: begin
                        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
                            if (dec[l].ok && dec[l].hart == 32'(h) && req_wstrb[4*l]) begin
                                msip_d[h] = req_wdata[32*l];
                            end
                        end
                    end
                    K_CMP: begin
                        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
                            if (dec[l].ok && dec[l].hart == 32'(h)) begin
                                for (int unsigned b = 0; b < 4; b++) begin
                                    if (req_wstrb[4*l+b]) begin
                                        mtimecmp_d[h][(dec[l].half ? 32 : 0) + 8*b +: 8] =
                                            req_wdata[32*l + 8*b +: 8];
                                    end
                                end
                            end
                        end
                    end
                    K_TIME: begin
                        mtime_wr = 1'b1;
                        for (int unsigned b = 0; b < 4; b++) begin
                            if (req_wstrb[4*l+b]) begin
                                mtime_wval[(dec[l].half ? 32 : 0) + 8*b +: 8] =
                                    req_wdata[32*l + 8*b +: 8];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // An MMIO write to mtime overrides a coincident tick and restarts the prescaler.
    always_comb begin
        tick    = !tm_inhibit && (presc_q == PRESC_MAX);
        presc_d = presc_q;
        if (!tm_inhibit) presc_d = tick ? '0 : presc_q + PW'(1);
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (mtime_wr) begin
            mtime_d = mtime_wval;
            presc_d = '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    err_d        = acc_err;
                    rdata_d      = (acc_err || req_we) ? '0 : rd_word;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        mtip_d  = '0;
        stip_d  = '0;
        msipo_d = '0;
        for (int unsigned h = 0; h < NUM_HARTS; h++) begin
            mtip_d[h]  = (mtime_q >= mtimecmp_q[h]);
            stip_d[h]  = stce[h] & (mtime_q >= stimecmp[64*h +: 64]);
            msipo_d[h] = msip_q[h];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            presc_q      <= '0;
            mtime_q      <= '0;
            msip_q       <= '0;
            for (int unsigned h = 0; h < NUM_HARTS; h++) mtimecmp_q[h] <= '1;
            mtip_q       <= '0;
            stip_q       <= '0;
            msipo_q      <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            presc_q      <= presc_d;
            mtime_q      <= mtime_d;
            msip_q       <= msip_d;
            mtimecmp_q   <= mtimecmp_d;
            mtip_q       <= mtip_d;
            stip_q       <= stip_d;
            msipo_q      <= msipo_d;
        end
    end

endmodule
